adder56_share_arbiter: RTL
==========================

// Module: adder56_share_arbiter
// PURPOSE
//  Shares one 56-bit unsigned adder (A[55:0] + zero-extended B[54:0] -> Sum[56:0]) among
//  NUM_REQ requesters in the mantissa datapath, e.g. multiplier partial-sum, rounding and
//  normalisation stages. Round-robin arbitration, valid/ready handshake on every port,
//  one registered result slot tagged with the requester ID. Single adder instance only.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  A_W      56  width of operand A
//  B_W      55  width of operand B; zero-extended to A_W inside the block
//  SUM_W    57  result width (A_W+1); no carry is lost
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   NUM_REQ       request i presents operands
//  req_ready  out  NUM_REQ       request i accepted this cycle (valid&ready)
//  req_a      in   NUM_REQ*A_W   operand A, slice i = [i*A_W +: A_W]
//  req_b      in   NUM_REQ*B_W   operand B, slice i = [i*B_W +: B_W]
//  rsp_valid  out  1             result slot holds a result
//  rsp_ready  in   1             consumer takes result (valid&ready)
//  rsp_sum    out  SUM_W         A + {1'b0,B} of the accepted request
//  rsp_id     out  ID_W          index of the request that produced rsp_sum; ID_W=clog2(NUM_REQ)
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): rsp_valid=0, rsp_sum=0, rsp_id=0,
//    rr_ptr=0; req_ready=0 while rst_n=0. In-flight result is discarded, never replayed.
//  - Slot states: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//    EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept;
//    FULL->FULL on rsp_ready plus accept in the same cycle (back-to-back, no bubble).
//  - can_accept = ~rsp_valid | rsp_ready. grant = round-robin pick among req_valid,
//    starting at rr_ptr and searching upward with wrap-around.
//  - req_ready[i] = can_accept & grant[i]; combinational from req_valid/rsp_ready;
//    at most one bit set. No req_ready when no req_valid.
//  - On accept of i: rsp_sum <= req_a[i] + {1'b0,req_b[i]} (unsigned, full SUM_W),
//    rsp_id <= i, rsp_valid <= 1, rr_ptr <= (i+1) mod NUM_REQ. Latency accept->rsp_valid
//    = 1 cycle. Throughput 1 result/cycle while consumer is ready.
//  - rr_ptr is unchanged when no accept occurs (no accept when the slot is FULL and stalled).
//  - Stall: rsp_valid=1 & rsp_ready=0 -> rsp_sum/rsp_id held stable, all req_ready=0.
//  - Requesters must hold valid/operands stable until ready; the block does not buffer.
//  - Any requester waits at most NUM_REQ-1 grants while the consumer drains (starvation-free).
//  - Overflow impossible: max (2^56-1)+(2^55-1) fits in 57 bits.
// STRUCTURE
//  - Shared package adder56_pkg: A_W/B_W/SUM_W constants, ID_W=clog2(NUM_REQ),
//    typedef for operand/result vectors.
//  - Sub-module rr_arbiter (NUM_REQ): in req, ptr; out one-hot grant, grant_idx.
//  - Top: operand mux by grant_idx, one 56-bit adder instance with B zero-extended,
//    result/ID/valid registers, rr_ptr register.
// TESTING
//  1. Single req: req1 A=56'hFF_FFFF_FFFF_FFFF, B=55'h1 -> ready1 same cycle;
//     next cycle rsp_valid=1, rsp_sum=57'h100_0000_0000_0000, rsp_id=1.
//  2. Max operands: A=2^56-1, B=2^55-1 -> rsp_sum=57'h17F_FFFF_FFFF_FFFE (MSB carry kept).
//  3. All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one result per cycle;
//     rsp_id sequence 0,1,2,3,0.
//  4. rsp_ready=0 for 3 cycles with slot FULL -> rsp_sum/rsp_id stable, req_ready=0,
//     rr_ptr frozen. Raise rsp_ready -> next pending request accepted that same cycle.
//  5. rst_n pulled low mid-stream with slot FULL -> rsp_valid=0 immediately (async);
//     after release, first grant goes to lowest-index valid requester (rr_ptr=0).
//  6. Randomised valid/ready with scoreboard: every accepted (id,A,B) yields exactly one
//     response in order with the correct sum; no requester waits more than 3 grants.

Source files
------------

// File: rtl/adder56_pkg.sv
// Shared widths and types for the shared 56-bit mantissa adder.
package adder56_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int A_W         = 56;
  localparam int B_W         = 55;
  localparam int SUM_W       = A_W + 1;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef logic [A_W-1:0]   a_t;
  typedef logic [B_W-1:0]   b_t;
  typedef logic [SUM_W-1:0] sum_t;

  function automatic a_t zext_b(input b_t b);
    return {{(A_W-B_W){1'b0}}, b};
  endfunction
endpackage

// File: rtl/adder56_share_arbiter_if.sv
// Request/response bundle between the mantissa stages and the shared adder.
interface adder56_share_arbiter_if
  import adder56_pkg::*;
  #(parameter int NUM_REQ = DEF_NUM_REQ);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  sum_t                   rsp_sum;
  logic [ID_W-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/adder56_share_arbiter_rr_arbiter.sv
// Round-robin picker: first valid request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/adder56_share_arbiter.sv
// One shared 56+55 bit adder behind a round-robin arbiter and a single result slot.
module adder56_share_arbiter
  import adder56_pkg::*;
  #(parameter int NUM_REQ = DEF_NUM_REQ)
(
  input  logic                     clk,
  input  logic                     rst_n,
  adder56_share_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  a_t                 a_arr [NUM_REQ];
  b_t                 b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_ptr;
  logic               can_accept;
  logic               accept;
  a_t                 a_p0;
  b_t                 b_p0;
  sum_t               sum_p0;
  logic               vld_p1;
  sum_t               sum_p1;
  logic [ID_W-1:0]    id_p1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*A_W +: A_W];
    assign b_arr[g] = bus.req_b[g*B_W +: B_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Slot frees up in the same cycle the consumer drains it, so no bubble between results.
  assign can_accept    = ~vld_p1 | bus.rsp_ready;
  assign bus.req_ready = (rst_n && can_accept) ? grant : '0;
  assign accept        = |bus.req_ready;

  // Stage p0: operand mux and the single shared adder
  assign a_p0   = a_arr[grant_idx];
  assign b_p0   = b_arr[grant_idx];
  assign sum_p0 = {1'b0, a_p0} + {1'b0, zext_b(b_p0)};

  // Stage p1: result slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      id_p1  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      sum_p1 <= sum_p0;
      id_p1  <= grant_idx;
      rr_ptr <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
    end else if (bus.rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_sum   = sum_p1;
  assign bus.rsp_id    = id_p1;
endmodule
